// File: rtl/clock_pkg.sv
// Shared types, field limits and calendar helpers
// for the clock set controller.
package clock_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    HOUR  = 3'd1,
    MIN   = 3'd2,
    SEC   = 3'd3,
    DAY   = 3'd4,
    MONTH = 3'd5,
    YEAR  = 3'd6
  } field_e;

  typedef enum logic [2:0] {
    S_RUN,
    S_HOUR,
    S_MIN,
    S_SEC,
    S_DAY,
    S_MONTH,
    S_YEAR,
    S_COMMIT
  } state_e;

  localparam logic [4:0]  HOUR_MAX  = 5'd23;
  localparam logic [5:0]  MIN_MAX   = 6'd59;
  localparam logic [5:0]  SEC_MAX   = 6'd59;
  localparam logic [4:0]  DAY_MIN   = 5'd1;
  localparam logic [3:0]  MONTH_MIN = 4'd1;
  localparam logic [3:0]  MONTH_MAX = 4'd12;
  localparam logic [13:0] YEAR_MAX  = 14'd9999;

  localparam logic [4:0]  RST_DAY   = 5'd1;
  localparam logic [3:0]  RST_MONTH = 4'd1;
  localparam logic [13:0] RST_YEAR  = 14'd2024;

  function automatic logic is_leap(
    input logic [13:0] y
  );
    return ((y[1:0] == 2'b00) &&
            ((y % 14'd100) != 14'd0)) ||
           ((y % 14'd400) == 14'd0);
  endfunction

  function automatic logic [4:0] days_in_month(
    input logic [3:0]  m,
    input logic [13:0] y
  );
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2: d = is_leap(y) ? 5'd29 : 5'd28;
      default: d = 5'd31;
    endcase
    return d;
  endfunction

  function automatic logic [13:0] wrap_step(
    input logic [13:0] v,
    input logic [13:0] lo,
    input logic [13:0] hi,
    input logic        up
  );
    if (up)
      return (v >= hi) ? lo : v + 14'd1;
    return (v <= lo) ? hi : v - 14'd1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF sync, stability
// counter, one-cycle pulse on an accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [W-1:0] CNT_MAX =
    W'(DEBOUNCE_CYC - 1);

  logic         s1;
  logic         s2;
  logic         stable;
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt    <= '0;
        stable <= s2;
        // only the released->pressed edge pulses
        press  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time/date set-mode sequencer: 1 Hz enable, button
// driven shadow editing and atomic commit load.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_change_n,
  input  logic        btn_inc_n,
  input  logic        btn_dec_n,
  input  logic [5:0]  cur_sec,
  input  logic [5:0]  cur_min,
  input  logic [4:0]  cur_hour,
  input  logic [4:0]  cur_day,
  input  logic [3:0]  cur_month,
  input  logic [13:0] cur_year,
  output logic        tick_1hz,
  output logic        load,
  output logic [5:0]  ld_sec,
  output logic [5:0]  ld_min,
  output logic [4:0]  ld_hour,
  output logic [4:0]  ld_day,
  output logic [3:0]  ld_month,
  output logic [13:0] ld_year,
  output logic        edit_active,
  output logic [2:0]  edit_field,
  output logic        blink
);

  localparam int DIV_W = $clog2(CLK_HZ + 1);
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLK_HZ - 1);
  localparam int BLK_N =
    (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int BLK_W = $clog2(BLK_N + 1);
  localparam logic [BLK_W-1:0] BLK_MAX =
    BLK_W'(BLK_N - 1);

  state_e state_q;
  state_e state_d;

  logic chg_p;
  logic inc_p;
  logic dec_p;
  logic adj_up;
  logic adj_dn;

  logic [5:0]  sh_sec;
  logic [5:0]  sh_min;
  logic [4:0]  sh_hour;
  logic [4:0]  sh_day;
  logic [3:0]  sh_month;
  logic [13:0] sh_year;
  logic [4:0]  dmax;

  logic [13:0] fv;
  logic [13:0] flo;
  logic [13:0] fhi;
  logic [13:0] fnv;

  logic [DIV_W-1:0] div_q;
  logic [BLK_W-1:0] blk_cnt;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
    u_db_chg (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_change_n),
    .press(chg_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
    u_db_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_inc_n),
    .press(inc_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
    u_db_dec (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_dec_n),
    .press(dec_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    tick_1hz    = 1'b0;
    edit_active = 1'b0;
    edit_field  = NONE;
    case (state_q)
      S_RUN: begin
        tick_1hz = (div_q == DIV_MAX);
        if (chg_p) state_d = S_HOUR;
      end
      S_HOUR: begin
        edit_active = 1'b1;
        edit_field  = HOUR;
        if (chg_p) state_d = S_MIN;
      end
      S_MIN: begin
        edit_active = 1'b1;
        edit_field  = MIN;
        if (chg_p) state_d = S_SEC;
      end
      S_SEC: begin
        edit_active = 1'b1;
        edit_field  = SEC;
        if (chg_p) state_d = S_DAY;
      end
      S_DAY: begin
        edit_active = 1'b1;
        edit_field  = DAY;
        if (chg_p) state_d = S_MONTH;
      end
      S_MONTH: begin
        edit_active = 1'b1;
        edit_field  = MONTH;
        if (chg_p) state_d = S_YEAR;
      end
      S_YEAR: begin
        edit_active = 1'b1;
        edit_field  = YEAR;
        if (chg_p) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        load    = 1'b1;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // change outranks inc/dec; inc with dec cancels
  assign adj_up = edit_active & inc_p
                & ~dec_p & ~chg_p;
  assign adj_dn = edit_active & dec_p
                & ~inc_p & ~chg_p;

  assign dmax = days_in_month(sh_month, sh_year);

  always_comb begin
    fv  = '0;
    flo = '0;
    fhi = '0;
    unique case (1'b1)
      state_q == S_HOUR: begin
        fv  = 14'(sh_hour);
        fhi = 14'(HOUR_MAX);
      end
      state_q == S_MIN: begin
        fv  = 14'(sh_min);
        fhi = 14'(MIN_MAX);
      end
      state_q == S_SEC: begin
        fv  = 14'(sh_sec);
        fhi = 14'(SEC_MAX);
      end
      state_q == S_DAY: begin
        fv  = 14'(sh_day);
        flo = 14'(DAY_MIN);
        fhi = 14'(dmax);
      end
      state_q == S_MONTH: begin
        fv  = 14'(sh_month);
        flo = 14'(MONTH_MIN);
        fhi = 14'(MONTH_MAX);
      end
      state_q == S_YEAR: begin
        fv  = sh_year;
        fhi = YEAR_MAX;
      end
      default: ;
    endcase
    fnv = wrap_step(fv, flo, fhi, adj_up);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_sec   <= '0;
      sh_min   <= '0;
      sh_hour  <= '0;
      sh_day   <= RST_DAY;
      sh_month <= RST_MONTH;
      sh_year  <= RST_YEAR;
    end else if (state_q == S_RUN && chg_p) begin
      sh_sec   <= cur_sec;
      sh_min   <= cur_min;
      sh_hour  <= cur_hour;
      sh_day   <= cur_day;
      sh_month <= cur_month;
      sh_year  <= cur_year;
    end else if (state_q == S_YEAR && chg_p) begin
      if (sh_day > dmax) sh_day <= dmax;
    end else if (adj_up || adj_dn) begin
      unique case (1'b1)
        state_q == S_HOUR:  sh_hour  <= fnv[4:0];
        state_q == S_MIN:   sh_min   <= fnv[5:0];
        state_q == S_SEC:   sh_sec   <= fnv[5:0];
        state_q == S_DAY:   sh_day   <= fnv[4:0];
        state_q == S_MONTH: sh_month <= fnv[3:0];
        state_q == S_YEAR:  sh_year  <= fnv;
        default: ;
      endcase
    end
  end

  // divider restarts from 0 after every commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (state_q == S_RUN) begin
      if (div_q == DIV_MAX) div_q <= '0;
      else                  div_q <= div_q + 1'b1;
    end else begin
      div_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (state_d != state_q) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (edit_active) begin
      if (blk_cnt == BLK_MAX) begin
        blk_cnt <= '0;
        blink   <= ~blink;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end else begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end
  end

  assign ld_sec   = sh_sec;
  assign ld_min   = sh_min;
  assign ld_hour  = sh_hour;
  assign ld_day   = sh_day;
  assign ld_month = sh_month;
  assign ld_year  = sh_year;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small
// clock and debounce constants.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_change_n;
  logic        btn_inc_n;
  logic        btn_dec_n;
  logic [5:0]  cur_sec;
  logic [5:0]  cur_min;
  logic [4:0]  cur_hour;
  logic [4:0]  cur_day;
  logic [3:0]  cur_month;
  logic [13:0] cur_year;
  logic        tick_1hz;
  logic        load;
  logic [5:0]  ld_sec;
  logic [5:0]  ld_min;
  logic [4:0]  ld_hour;
  logic [4:0]  ld_day;
  logic [3:0]  ld_month;
  logic [13:0] ld_year;
  logic        edit_active;
  logic [2:0]  edit_field;
  logic        blink;

  int total = 0;
  int bad   = 0;
  int tick_seen = 0;
  int load_seen = 0;

  clock_set_ctrl #(
    .CLK_HZ      (8),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_change_n(btn_change_n),
    .btn_inc_n   (btn_inc_n),
    .btn_dec_n   (btn_dec_n),
    .cur_sec     (cur_sec),
    .cur_min     (cur_min),
    .cur_hour    (cur_hour),
    .cur_day     (cur_day),
    .cur_month   (cur_month),
    .cur_year    (cur_year),
    .tick_1hz    (tick_1hz),
    .load        (load),
    .ld_sec      (ld_sec),
    .ld_min      (ld_min),
    .ld_hour     (ld_hour),
    .ld_day      (ld_day),
    .ld_month    (ld_month),
    .ld_year     (ld_year),
    .edit_active (edit_active),
    .edit_field  (edit_field),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick_1hz) tick_seen++;
      if (load) load_seen++;
    end
  endtask

  task automatic press(
    input logic c,
    input logic i,
    input logic d
  );
    btn_change_n = ~c;
    btn_inc_n    = ~i;
    btn_dec_n    = ~d;
    cyc(8);
    btn_change_n = 1'b1;
    btn_inc_n    = 1'b1;
    btn_dec_n    = 1'b1;
    cyc(8);
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    btn_change_n = 1'b0;
    while (load !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("load_arrives", 32'(load), 1);
  endtask

  task automatic after_load();
    int n;
    n = 0;
    btn_change_n = 1'b1;
    do begin
      cyc(1);
      n++;
    end while (tick_1hz !== 1'b1 && n < 20);
    chk("tick_after_load", 32'(n), 8);
    cyc(8);
  endtask

  initial begin
    int n;
    int t0;
    int l0;
    int tg;
    logic pb;
    rst_n        = 1'b0;
    btn_change_n = 1'b1;
    btn_inc_n    = 1'b1;
    btn_dec_n    = 1'b1;
    cur_sec   = 6'd45;
    cur_min   = 6'd0;
    cur_hour  = 5'd23;
    cur_day   = 5'd30;
    cur_month = 4'd1;
    cur_year  = 14'd2023;
    cyc(3);
    chk("rst_tick",  32'(tick_1hz), 0);
    chk("rst_load",  32'(load), 0);
    chk("rst_year",  32'(ld_year), 2024);
    chk("rst_day",   32'(ld_day), 1);
    chk("rst_month", 32'(ld_month), 1);
    chk("rst_hour",  32'(ld_hour), 0);
    chk("rst_field", 32'(edit_field), 0);
    chk("rst_act",   32'(edit_active), 0);
    chk("rst_blink", 32'(blink), 0);
    rst_n = 1'b1;

    n = 0;
    while (tick_1hz !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("first_tick", 32'(tick_1hz), 1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        cyc(1);
        n++;
      end while (tick_1hz !== 1'b1 && n < 20);
      chk("tick_period", 32'(n), 8);
    end
    chk("run_load", 32'(load_seen), 0);

    // bouncy change press: low/high/low, then held
    btn_change_n = 1'b0;
    cyc(1);
    btn_change_n = 1'b1;
    cyc(1);
    btn_change_n = 1'b0;
    cyc(12);
    btn_change_n = 1'b1;
    cyc(8);
    t0 = tick_seen;
    chk("enter_field", 32'(edit_field), 1);
    chk("enter_act",   32'(edit_active), 1);
    chk("shadow_hour", 32'(ld_hour), 23);
    chk("shadow_sec",  32'(ld_sec), 45);
    chk("shadow_year", 32'(ld_year), 2023);

    press(0, 1, 0);
    chk("hour_wrap", 32'(ld_hour), 0);

    n  = 0;
    pb = blink;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (blink !== pb) n++;
      pb = blink;
    end
    chk("blink_toggles", 32'(n), 4);

    press(1, 0, 0);
    chk("field_min", 32'(edit_field), 2);
    press(0, 0, 1);
    chk("min_wrap", 32'(ld_min), 59);

    btn_change_n = 1'b0;
    n = 0;
    while (edit_field !== 3'd3 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("field_sec", 32'(edit_field), 3);
    chk("blink_ph0", 32'(blink), 0);
    cyc(1);
    chk("blink_ph1", 32'(blink), 0);
    cyc(1);
    chk("blink_ph2", 32'(blink), 1);
    btn_change_n = 1'b1;
    cyc(8);

    press(1, 0, 0);
    chk("field_day", 32'(edit_field), 4);
    press(0, 1, 0);
    chk("day_inc", 32'(ld_day), 31);
    press(0, 1, 1);
    chk("inc_dec_same", 32'(ld_day), 31);
    press(0, 1, 0);
    chk("day_wrap_up", 32'(ld_day), 1);
    press(0, 0, 1);
    chk("day_wrap_dn", 32'(ld_day), 31);

    press(1, 1, 0);
    chk("chg_inc_field", 32'(edit_field), 5);
    chk("chg_inc_month", 32'(ld_month), 1);
    chk("chg_inc_day",   32'(ld_day), 31);
    repeat (3) press(0, 1, 0);
    chk("month_set", 32'(ld_month), 4);
    press(1, 0, 0);
    chk("field_year", 32'(edit_field), 6);
    press(0, 0, 1);
    chk("year_dec", 32'(ld_year), 2022);
    tg = tick_seen;
    chk("no_tick_edit", 32'(tg - t0), 0);

    l0 = load_seen;
    wait_load();
    chk("c1_day",   32'(ld_day), 30);
    chk("c1_month", 32'(ld_month), 4);
    chk("c1_year",  32'(ld_year), 2022);
    chk("c1_hour",  32'(ld_hour), 0);
    chk("c1_min",   32'(ld_min), 59);
    chk("c1_field", 32'(edit_field), 0);
    after_load();
    chk("c1_pulses", 32'(load_seen - l0), 1);
    chk("run_blink", 32'(blink), 0);

    cur_hour  = 5'd5;
    cur_day   = 5'd29;
    cur_month = 4'd2;
    cur_year  = 14'd1900;
    repeat (6) press(1, 0, 0);
    wait_load();
    chk("y1900_day", 32'(ld_day), 28);
    after_load();

    cur_year = 14'd2000;
    repeat (6) press(1, 0, 0);
    wait_load();
    chk("y2000_day", 32'(ld_day), 29);
    after_load();

    cur_year = 14'd9999;
    repeat (6) press(1, 0, 0);
    press(0, 1, 0);
    chk("year_wrap", 32'(ld_year), 0);
    wait_load();
    chk("y0_day", 32'(ld_day), 29);
    after_load();

    press(0, 1, 0);
    chk("run_inc_field", 32'(edit_field), 0);
    chk("run_inc_hour",  32'(ld_hour), 5);

    cur_year = 14'd1999;
    repeat (4) press(1, 0, 0);
    chk("pre_rst_field", 32'(edit_field), 4);
    l0 = load_seen;
    rst_n = 1'b0;
    cyc(3);
    chk("mid_rst_field", 32'(edit_field), 0);
    chk("mid_rst_year",  32'(ld_year), 2024);
    rst_n = 1'b1;
    cyc(12);
    chk("post_rst_act",  32'(edit_active), 0);
    chk("post_rst_load", 32'(load_seen - l0), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
